// File: rtl/sprite_compositor.sv
// sprite_compositor
//   Composites NUM_SPRITES RGB565 sprites over a programmable background
//   between the VGA timing generator and the DAC pins. Channel 0 is the top
//   layer. Avalon-MM writes land in shadow registers that are copied to the
//   active set once per frame, at vcount==VACTIVE && hcount==0. The bench of
//   opaque-overlap flags for a frame, and a frame counter, are readable.
//
// Ports
//   clk, reset                 system clock, synchronous active-low reset
//   chipselect/write/read      Avalon-MM slave controls
//   address[8:0], writedata    word address / write data
//   readdata[31:0]             registered read data (1-cycle latency)
//   hcount[10:0], vcount[9:0]  timing generator counters (pixel x = hcount[10:1])
//   hs_in, vs_in, blank_n_in   undelayed sync / blank
//   rom_addr                   per-channel sprite ROM address, channel i in slice i
//   rom_data                   per-channel RGB565 from 1-cycle synchronous ROMs
//   VGA_R/G/B                  8-bit colour, 3 clocks after hcount
//   VGA_HS/VS/BLANK_n          sync / blank delayed to line up with colour
module sprite_compositor #(
    parameter int NUM_SPRITES = 4,
    parameter int SPRITE_W    = 32,
    parameter int SPRITE_H    = 32,
    parameter int VACTIVE     = 480,
    parameter int ADDR_W      = $clog2(SPRITE_W * SPRITE_H)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          chipselect,
    input  logic                          write,
    input  logic                          read,
    input  logic [8:0]                    address,
    input  logic [31:0]                   writedata,
    output logic [31:0]                   readdata,
    input  logic [10:0]                   hcount,
    input  logic [9:0]                    vcount,
    input  logic                          hs_in,
    input  logic                          vs_in,
    input  logic                          blank_n_in,
    output logic [NUM_SPRITES*ADDR_W-1:0] rom_addr,
    input  logic [NUM_SPRITES*16-1:0]     rom_data,
    output logic [7:0]                    VGA_R,
    output logic [7:0]                    VGA_G,
    output logic [7:0]                    VGA_B,
    output logic                          VGA_HS,
    output logic                          VGA_VS,
    output logic                          VGA_BLANK_n
);

    localparam int unsigned NU = NUM_SPRITES;

    // Shadow (software-visible) and active (display) register sets
    logic [9:0]             r_sh_x   [NUM_SPRITES];
    logic [9:0]             r_sh_y   [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] r_sh_en;
    logic [NUM_SPRITES-1:0] r_sh_flip;
    logic [15:0]            r_sh_bg;
    logic [15:0]            r_sh_key;
    logic [9:0]             r_act_x  [NUM_SPRITES];
    logic [9:0]             r_act_y  [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] r_act_en;
    logic [NUM_SPRITES-1:0] r_act_flip;
    logic [15:0]            r_act_bg;
    logic [15:0]            r_act_key;

    logic [NUM_SPRITES-1:0] r_coll;
    logic [NUM_SPRITES-1:0] r_accum;
    logic [15:0]            r_frame;

    // Pixel pipeline state
    logic [NUM_SPRITES-1:0] r_hit1;
    logic [NUM_SPRITES-1:0] r_hit2;
    logic [1:0]             r_hs_d;
    logic [1:0]             r_vs_d;
    logic [1:0]             r_bl_d;

    logic                   w_commit;
    logic                   w_wr;
    logic                   w_rd;
    logic [9:0]             w_px;
    logic [NUM_SPRITES-1:0] w_hit;
    logic [9:0]             w_col    [NUM_SPRITES];
    logic [9:0]             w_row    [NUM_SPRITES];
    logic [ADDR_W-1:0]      w_addr   [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] w_opaque;
    logic                   w_multi;
    logic [15:0]            w_pix;
    logic [31:0]            w_rd_val;
    logic                   w_unused;

    assign w_commit = (vcount == 10'(VACTIVE)) && (hcount == '0);
    assign w_wr     = chipselect && write;
    assign w_rd     = chipselect && read;
    assign w_px     = hcount[10:1];
    assign w_unused = &{1'b0, writedata[31:16]};

    // Hit test and ROM address, all bounds in 11 bits so x+SPRITE_W never wraps
    always_comb begin
        w_hit = '0;
        for (int unsigned i = 0; i < NU; i++) begin
            w_hit[i] = r_act_en[i]
                && ({1'b0, w_px} >= {1'b0, r_act_x[i]})
                && ({1'b0, w_px} <  ({1'b0, r_act_x[i]} + 11'(SPRITE_W)))
                && ({1'b0, vcount} >= {1'b0, r_act_y[i]})
                && ({1'b0, vcount} <  ({1'b0, r_act_y[i]} + 11'(SPRITE_H)));
            w_row[i]  = vcount - r_act_y[i];
            w_col[i]  = r_act_flip[i] ? (10'(SPRITE_W - 1) - (w_px - r_act_x[i]))
                                      : (w_px - r_act_x[i]);
            w_addr[i] = ADDR_W'({22'b0, w_col[i]} + ({22'b0, w_row[i]} * 32'(SPRITE_W)));
        end
    end

    // Opacity and priority select on the cycle the ROM data is valid
    always_comb begin
        w_opaque = '0;
        w_pix    = r_act_bg;
        for (int unsigned i = 0; i < NU; i++) begin
            w_opaque[i] = r_hit2[i] && (rom_data[i*16 +: 16] != r_act_key);
        end
        // Walk from the bottom layer up so the lowest opaque index wins
        for (int unsigned i = NU; i > 0; i--) begin
            if (w_opaque[i-1]) begin
                w_pix = rom_data[(i-1)*16 +: 16];
            end
        end
    end

    // Clearing the lowest set bit leaves something only if two or more are set
    assign w_multi = |(w_opaque & (w_opaque - NUM_SPRITES'(1)));

    // Register read mux (shadow copies, live collision/frame count)
    always_comb begin
        w_rd_val = '0;
        for (int unsigned i = 0; i < NU; i++) begin
            if (address == 9'(4*i))     w_rd_val = {22'b0, r_sh_x[i]};
            if (address == 9'(4*i + 1)) w_rd_val = {22'b0, r_sh_y[i]};
            if (address == 9'(4*i + 2)) w_rd_val = {30'b0, r_sh_flip[i], r_sh_en[i]};
        end
        case (address)
            9'h100:  w_rd_val = {16'b0, r_sh_bg};
            9'h101:  w_rd_val = {16'b0, r_sh_key};
            9'h102: begin
                for (int unsigned i = 0; i < NU && i < 32; i++) begin
                    w_rd_val[i] = r_coll[i];
                end
            end
            9'h103:  w_rd_val = {16'b0, r_frame};
            default: ;
        endcase
    end

    // Registers: shadow writes, frame commit, collision accumulation
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NU; i++) begin
                r_sh_x[i]  <= '0;
                r_sh_y[i]  <= '0;
                r_act_x[i] <= '0;
                r_act_y[i] <= '0;
            end
            r_sh_en    <= '0;
            r_sh_flip  <= '0;
            r_act_en   <= '0;
            r_act_flip <= '0;
            r_sh_bg    <= 16'hFFFF;
            r_act_bg   <= 16'hFFFF;
            r_sh_key   <= 16'hF81F;
            r_act_key  <= 16'hF81F;
            r_coll     <= '0;
            r_accum    <= '0;
            r_frame    <= '0;
            readdata   <= '0;
        end else begin
            if (w_rd) begin
                readdata <= w_rd_val;
            end
            // Active copies take the pre-write shadow value when a write
            // coincides with the commit
            if (w_commit) begin
                for (int unsigned i = 0; i < NU; i++) begin
                    r_act_x[i] <= r_sh_x[i];
                    r_act_y[i] <= r_sh_y[i];
                end
                r_act_en   <= r_sh_en;
                r_act_flip <= r_sh_flip;
                r_act_bg   <= r_sh_bg;
                r_act_key  <= r_sh_key;
                r_coll     <= r_accum;
                r_accum    <= '0;
                r_frame    <= r_frame + 16'd1;
            end else if (r_bl_d[1] && w_multi) begin
                r_accum <= r_accum | w_opaque;
            end
            if (w_wr) begin
                for (int unsigned i = 0; i < NU; i++) begin
                    if (address == 9'(4*i))     r_sh_x[i] <= writedata[9:0];
                    if (address == 9'(4*i + 1)) r_sh_y[i] <= writedata[9:0];
                    if (address == 9'(4*i + 2)) begin
                        r_sh_en[i]   <= writedata[0];
                        r_sh_flip[i] <= writedata[1];
                    end
                end
                if (address == 9'h100) r_sh_bg  <= writedata[15:0];
                if (address == 9'h101) r_sh_key <= writedata[15:0];
            end
        end
    end

    // Pixel pipeline: hit/address, ROM wait, colour out
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hit1      <= '0;
            r_hit2      <= '0;
            rom_addr    <= '0;
            r_hs_d      <= '1;
            r_vs_d      <= '1;
            r_bl_d      <= '0;
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_n <= 1'b0;
        end else begin
            r_hit1 <= w_hit;
            r_hit2 <= r_hit1;
            for (int unsigned i = 0; i < NU; i++) begin
                if (w_hit[i]) begin
                    rom_addr[i*ADDR_W +: ADDR_W] <= w_addr[i];
                end
            end
            r_hs_d      <= {r_hs_d[0], hs_in};
            r_vs_d      <= {r_vs_d[0], vs_in};
            r_bl_d      <= {r_bl_d[0], blank_n_in};
            VGA_HS      <= r_hs_d[1];
            VGA_VS      <= r_vs_d[1];
            VGA_BLANK_n <= r_bl_d[1];
            if (r_bl_d[1]) begin
                VGA_R <= {w_pix[15:11], w_pix[15:13]};
                VGA_G <= {w_pix[10:5],  w_pix[10:9]};
                VGA_B <= {w_pix[4:0],   w_pix[4:2]};
            end else begin
                VGA_R <= '0;
                VGA_G <= '0;
                VGA_B <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sprite_compositor.sv
// tb_sprite_compositor
//   Drives sprite_compositor with directed and $urandom pixel/register
//   traffic and compares colour, sync, ROM addresses and readback against
//   a frame-level reference model of the compositor held in the bench.
module tb_sprite_compositor;

    localparam int NS = 4;
    localparam int SW = 32;
    localparam int SH = 32;
    localparam int VA = 480;
    localparam int AW = 10;

    logic              clk;
    logic              reset;
    logic              chipselect, write, read;
    logic [8:0]        address;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic [10:0]       hcount;
    logic [9:0]        vcount;
    logic              hs_in, vs_in, blank_n_in;
    logic [NS*AW-1:0]  rom_addr;
    logic [NS*16-1:0]  rom_data;
    logic [7:0]        VGA_R, VGA_G, VGA_B;
    logic              VGA_HS, VGA_VS, VGA_BLANK_n;

    sprite_compositor #(
        .NUM_SPRITES(NS),
        .SPRITE_W(SW),
        .SPRITE_H(SH),
        .VACTIVE(VA)
    ) dut (
        .clk(clk), .reset(reset),
        .chipselect(chipselect), .write(write), .read(read),
        .address(address), .writedata(writedata), .readdata(readdata),
        .hcount(hcount), .vcount(vcount),
        .hs_in(hs_in), .vs_in(vs_in), .blank_n_in(blank_n_in),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_n(VGA_BLANK_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sprite ROMs: one-cycle synchronous read
    logic [15:0] rom_mem [NS][SW*SH];
    always @(posedge clk) begin
        for (int i = 0; i < NS; i++) begin
            rom_data[i*16 +: 16] <= rom_mem[i][rom_addr[i*AW +: AW]];
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int          m_sh_x [NS], m_sh_y [NS], m_act_x [NS], m_act_y [NS];
    bit          m_sh_en [NS], m_sh_fl [NS], m_act_en [NS], m_act_fl [NS];
    logic [15:0] m_sh_bg, m_sh_key, m_act_bg, m_act_key;
    logic [NS-1:0] m_accum, m_coll;
    logic [15:0] m_frame;
    int          m_addr [NS];

    typedef struct {
        logic [23:0] rgb;
        logic        bl;
        logic        hs;
        logic        vs;
    } exp_t;
    exp_t q[$];

    task automatic m_reset();
        for (int i = 0; i < NS; i++) begin
            m_sh_x[i] = 0; m_sh_y[i] = 0; m_act_x[i] = 0; m_act_y[i] = 0;
            m_sh_en[i] = 0; m_sh_fl[i] = 0; m_act_en[i] = 0; m_act_fl[i] = 0;
            m_addr[i] = 0;
        end
        m_sh_bg = 16'hFFFF; m_act_bg = 16'hFFFF;
        m_sh_key = 16'hF81F; m_act_key = 16'hF81F;
        m_accum = '0; m_coll = '0; m_frame = '0;
    endtask

    function automatic logic [31:0] m_read(input int a);
        logic [31:0] r;
        r = '0;
        if (a < 4*NS) begin
            case (a % 4)
                0: r = 32'(m_sh_x[a/4]);
                1: r = 32'(m_sh_y[a/4]);
                2: r = {30'b0, m_sh_fl[a/4], m_sh_en[a/4]};
                default: r = '0;
            endcase
        end else if (a == 'h100) r = {16'b0, m_sh_bg};
        else if (a == 'h101) r = {16'b0, m_sh_key};
        else if (a == 'h102) r = 32'(m_coll);
        else if (a == 'h103) r = {16'b0, m_frame};
        return r;
    endfunction

    task automatic m_write(input int a, input logic [31:0] d);
        if (a < 4*NS) begin
            case (a % 4)
                0: m_sh_x[a/4] = int'(d[9:0]);
                1: m_sh_y[a/4] = int'(d[9:0]);
                2: begin m_sh_en[a/4] = d[0]; m_sh_fl[a/4] = d[1]; end
                default: ;
            endcase
        end else if (a == 'h100) m_sh_bg = d[15:0];
        else if (a == 'h101) m_sh_key = d[15:0];
    endtask

    // One clock: model the inputs now on the pins, advance, then compare
    task automatic cyc();
        exp_t        e;
        int          px, v, col, row, a;
        logic [15:0] win;
        bit          found, do_rd;
        logic [NS-1:0] opq;
        logic [31:0] rd_exp;
        if (!reset) begin
            m_reset();
            q.delete();
            @(posedge clk); @(negedge clk);
            check_val("rst_rgb", {VGA_R, VGA_G, VGA_B}, 0);
            check_val("rst_blank", VGA_BLANK_n, 0);
            check_val("rst_sync", {VGA_HS, VGA_VS}, 2'b11);
            check_val("rst_rdata", readdata, 0);
            check_val("rst_romaddr", rom_addr, 0);
            return;
        end
        px = int'(hcount[10:1]);
        v  = int'(vcount);
        found = 0; opq = '0; win = m_act_bg; rd_exp = '0;
        for (int i = 0; i < NS; i++) begin
            if (m_act_en[i] && px >= m_act_x[i] && px < m_act_x[i] + SW &&
                v >= m_act_y[i] && v < m_act_y[i] + SH) begin
                col = px - m_act_x[i];
                if (m_act_fl[i]) col = SW - 1 - col;
                row = v - m_act_y[i];
                a = row * SW + col;
                m_addr[i] = a;
                if (rom_mem[i][a] != m_act_key) begin
                    opq[i] = 1'b1;
                    if (!found) begin win = rom_mem[i][a]; found = 1; end
                end
            end
        end
        e.bl  = blank_n_in;
        e.hs  = hs_in;
        e.vs  = vs_in;
        e.rgb = blank_n_in ? {win[15:11], win[15:13], win[10:5], win[10:9], win[4:0], win[4:2]} : 24'h0;
        if (blank_n_in && $countones(opq) >= 2) m_accum = m_accum | opq;
        do_rd = chipselect && read;
        if (do_rd) rd_exp = m_read(int'(address));
        if (int'(vcount) == VA && hcount == 0) begin
            for (int i = 0; i < NS; i++) begin
                m_act_x[i] = m_sh_x[i]; m_act_y[i] = m_sh_y[i];
                m_act_en[i] = m_sh_en[i]; m_act_fl[i] = m_sh_fl[i];
            end
            m_act_bg = m_sh_bg; m_act_key = m_sh_key;
            m_coll = m_accum; m_accum = '0;
            m_frame = m_frame + 16'd1;
        end
        if (chipselect && write) m_write(int'(address), writedata);
        q.push_back(e);
        @(posedge clk); @(negedge clk);
        if (q.size() == 3) begin
            e = q.pop_front();
            check_val("pix_rgb", {VGA_R, VGA_G, VGA_B}, e.rgb);
            check_val("pix_blank", VGA_BLANK_n, e.bl);
            check_val("pix_sync", {VGA_HS, VGA_VS}, {e.hs, e.vs});
        end
        for (int i = 0; i < NS; i++) begin
            check_val("rom_addr", rom_addr[i*AW +: AW], m_addr[i]);
        end
        if (do_rd) check_val("readdata", readdata, rd_exp);
    endtask

    task automatic idle();
        hcount = 11'($urandom_range(0, 2047));
        vcount = 10'(VA + 20);
        blank_n_in = 1'b0;
        hs_in = 1'($urandom); vs_in = 1'($urandom);
        chipselect = 0; write = 0; read = 0;
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        idle(); chipselect = 1; write = 1; address = 9'(a); writedata = d;
        cyc();
        chipselect = 0; write = 0;
    endtask

    task automatic rd(input int a);
        idle(); chipselect = 1; read = 1; address = 9'(a);
        cyc();
        chipselect = 0; read = 0;
    endtask

    task automatic commit();
        repeat (3) begin idle(); cyc(); end
        idle(); vcount = 10'(VA); hcount = '0;
        cyc();
    endtask

    task automatic px_at(input int p, input int v);
        chipselect = 0; write = 0; read = 0;
        hcount = 11'(p * 2 + $urandom_range(0, 1));
        vcount = 10'(v);
        blank_n_in = 1'b1;
        hs_in = 1'($urandom); vs_in = 1'($urandom);
        cyc();
    endtask

    task automatic scan_box(input int x0, input int x1, input int y0, input int y1);
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++) px_at(x, y);
    endtask

    task automatic set_sprite(input int i, input int x, input int y, input int ctrl);
        wr(4*i, 32'(x)); wr(4*i + 1, 32'(y)); wr(4*i + 2, 32'(ctrl));
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        do w = 16'($urandom); while (w == 16'hF81F || w == 16'h0000);
        return w;
    endfunction

    initial begin
        for (int i = 0; i < NS; i++)
            for (int a = 0; a < SW*SH; a++) rom_mem[i][a] = rand_word();
        reset = 0; chipselect = 0; write = 0; read = 0;
        address = '0; writedata = '0;
        idle();
        @(negedge clk);
        cyc(); cyc();
        reset = 1;

        // Reset register values and unmapped read
        for (int a = 0; a < 4*NS; a++) rd(a);
        rd('h100); rd('h101); rd('h102); rd('h103); rd('h1FF);

        // Empty frame: background only
        commit();
        rd('h103);
        check_val("frame_one", readdata, 1);
        for (int k = 0; k < 100; k++) px_at($urandom_range(0, 1023), $urandom_range(0, VA-1));

        // Mid-frame write stays invisible until the commit
        set_sprite(0, 100, 100, 1);
        scan_box(95, 140, 100, 100);
        commit();
        scan_box(95, 140, 99, 101);

        // Unmapped writes are dropped
        wr(3, 32'hFFFF_FFFF); wr('h102, 32'hF); wr('h103, 32'h1234); wr('h1FF, 32'h55); wr(4*NS, 32'h3);
        rd(3); rd('h102); rd('h103); rd(4*NS);

        // Overlap at (50,50); sprite0's first word is the key
        rom_mem[0][0] = 16'hF81F;
        set_sprite(0, 50, 50, 1);
        set_sprite(1, 50, 50, 1);
        commit();
        scan_box(48, 58, 50, 51);
        commit();
        rd('h102);
        check_val("coll_both", readdata, 4'b0011);
        wr('h101, 0);
        commit();
        scan_box(49, 52, 50, 50);
        set_sprite(1, 300, 300, 1);
        commit();
        scan_box(48, 58, 50, 51);
        commit();
        rd('h102);
        check_val("coll_clear", readdata, 0);

        // hflip address mapping and right-edge clipping
        wr('h101, 32'hF81F);
        set_sprite(0, 10, 200, 3);
        set_sprite(1, 1010, 200, 1);
        commit();
        px_at(10, 200);
        check_val("flip_col31", rom_addr[AW-1:0], 31);
        px_at(41, 200);
        check_val("flip_col0", rom_addr[AW-1:0], 0);
        scan_box(1000, 1023, 200, 201);
        scan_box(0, 12, 200, 201);

        // Randomised frames with clustered sprites
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < NS; i++)
                set_sprite(i, 100 + $urandom_range(0, 60), 100 + $urandom_range(0, 60),
                           $urandom_range(0, 3) | ($urandom_range(0, 3) != 0 ? 1 : 0));
            wr('h100, $urandom);
            if (f % 2 == 1)
                wr('h101, 32'(rom_mem[$urandom_range(0, NS-1)][$urandom_range(0, SW*SH-1)]));
            else
                wr('h101, 32'hF81F);
            commit();
            for (int k = 0; k < 300; k++) begin
                chipselect = 0;
                hcount = 11'($urandom_range(180, 400));
                vcount = 10'($urandom_range(90, 200));
                blank_n_in = ($urandom_range(0, 9) != 0);
                hs_in = 1'($urandom); vs_in = 1'($urandom);
                cyc();
            end
            commit();
            rd('h102); rd('h103);
        end

        // Reset mid-line, then a write that coincides with the commit
        set_sprite(0, 0, 0, 0);
        commit();
        px_at(5, 5); px_at(6, 5);
        reset = 0;
        px_at(7, 5);
        reset = 1;
        for (int a = 0; a < 4*NS; a++) rd(a);
        rd('h100); rd('h101); rd('h102); rd('h103);
        repeat (3) begin idle(); cyc(); end
        idle(); vcount = 10'(VA); hcount = '0;
        chipselect = 1; write = 1; address = 9'd2; writedata = 32'd1;
        cyc();
        chipselect = 0; write = 0;
        scan_box(0, 20, 0, 2);
        rd(2);
        commit();
        scan_box(0, 20, 0, 2);
        rd('h103);
        check_val("frame_after_rst", readdata, 2);
        repeat (3) begin idle(); cyc(); end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #20_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
